// File: rtl/mux_arbiter_rr_if.sv
// Bundle of the requester-side and downstream-side signals of the round-robin
// channel arbiter; master is the arbiter, slave is the surrounding fabric.
interface mux_arbiter_rr_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] d;
  logic           q_ready;
  logic [N-1:0]   gnt;
  logic [SW-1:0]  sel;
  logic [N-1:0]   ack;
  logic           q_valid;
  logic [W-1:0]   q_data;
  logic           busy;

  modport master (
    input  req, d, q_ready,
    output gnt, sel, ack, q_valid, q_data, busy
  );

  modport slave (
    output req, d, q_ready,
    input  gnt, sel, ack, q_valid, q_data, busy
  );
endinterface

// File: rtl/mux_arbiter_rr.sv
// Round-robin arbiter sharing one W-bit valid/ready channel between N requesters,
// with bounded bursts per grant and same-edge re-arbitration on release.
module mux_arbiter_rr #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input logic             clk,
  input logic             rst_n,
  mux_arbiter_rr_if.master bus
);
  localparam int SW = $clog2(N);
  localparam int P  = 1 << SW;

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_r, state_nxt_s;
  logic [N-1:0]  gnt_r, gnt_nxt_s;
  logic [SW-1:0] sel_r, sel_nxt_s;
  logic [SW-1:0] ptr_r, ptr_nxt_s;
  logic [7:0]    cnt_r, cnt_nxt_s;
  logic [SW-1:0] rot_ptr_s, search_ptr_s, win_idx_s;
  logic          win_found_s;
  logic          req_sel_s, busy_s, q_valid_s, xfer_s, release_s;
  logic [N-1:0]  ack_s;
  logic [W-1:0]  q_data_s, mux_out_s;
  logic [W-1:0]  tree_s [P];

  // First requesting index at or after start, wrapping; MSB flags a hit.
  function automatic logic [SW:0] rr_pick(input logic [N-1:0] r, input logic [SW-1:0] start);
    logic [SW:0] res;
    res = {1'b0, {SW{1'b0}}};
    for (int k = N - 1; k >= 0; k--) begin
      if (r[(int'(start) + k) % N]) begin
        res = {1'b1, SW'((int'(start) + k) % N)};
      end
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [SW-1:0] i);
    return {{(N-1){1'b0}}, 1'b1} << i;
  endfunction

  function automatic logic [W-1:0] mux2(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    return s ? b : a;
  endfunction

  assign req_sel_s    = bus.req[sel_r];
  assign rot_ptr_s    = (sel_r == SW'(N - 1)) ? {SW{1'b0}} : sel_r + SW'(1);
  assign search_ptr_s = (state_r == GRANT) ? rot_ptr_s : ptr_r;
  assign {win_found_s, win_idx_s} = rr_pick(bus.req, search_ptr_s);

  // N:1 data mux as a tree of 2:1 muxes, one select bit per level.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      if (i < N) begin
        tree_s[i] = bus.d[i*W +: W];
      end else begin
        tree_s[i] = {W{1'b0}};
      end
    end
    for (int b = 0; b < SW; b++) begin
      for (int i = 0; i < (P >> (b + 1)); i++) begin
        tree_s[i] = mux2(tree_s[2*i], tree_s[2*i+1], sel_r[b]);
      end
    end
    mux_out_s = tree_s[0];
  end

  // State register: FSM state, grant, select, rotation pointer, beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      gnt_r   <= {N{1'b0}};
      sel_r   <= {SW{1'b0}};
      ptr_r   <= {SW{1'b0}};
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      gnt_r   <= gnt_nxt_s;
      sel_r   <= sel_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state: arbitration from IDLE, burst counting and release in GRANT.
  always_comb begin
    state_nxt_s = state_r;
    gnt_nxt_s   = gnt_r;
    sel_nxt_s   = sel_r;
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
    release_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_nxt_s = GRANT;
          gnt_nxt_s   = onehot(win_idx_s);
          sel_nxt_s   = win_idx_s;
          cnt_nxt_s   = 8'd0;
        end else begin
          gnt_nxt_s   = {N{1'b0}};
        end
      end
      GRANT: begin
        release_s = (xfer_s && (cnt_r == 8'(MAX_BURST - 1))) || !req_sel_s;
        if (release_s) begin
          // Released index sits last in the search because it starts at sel+1.
          ptr_nxt_s = rot_ptr_s;
          cnt_nxt_s = 8'd0;
          if (win_found_s) begin
            gnt_nxt_s = onehot(win_idx_s);
            sel_nxt_s = win_idx_s;
          end else begin
            state_nxt_s = IDLE;
            gnt_nxt_s   = {N{1'b0}};
          end
        end else if (xfer_s) begin
          cnt_nxt_s = cnt_r + 8'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = {N{1'b0}};
      end
    endcase
  end

  // Output decode: channel valid/data, per-requester ack and busy.
  always_comb begin
    busy_s    = 1'b0;
    q_valid_s = 1'b0;
    q_data_s  = {W{1'b0}};
    xfer_s    = 1'b0;
    ack_s     = {N{1'b0}};
    case (state_r)
      GRANT: begin
        busy_s    = 1'b1;
        q_valid_s = req_sel_s;
        q_data_s  = req_sel_s ? mux_out_s : {W{1'b0}};
        xfer_s    = req_sel_s & bus.q_ready;
        ack_s     = xfer_s ? onehot(sel_r) : {N{1'b0}};
      end
      default: begin
        busy_s    = 1'b0;
      end
    endcase
  end

  assign bus.gnt     = gnt_r;
  assign bus.sel     = sel_r;
  assign bus.ack     = ack_s;
  assign bus.q_valid = q_valid_s;
  assign bus.q_data  = q_data_s;
  assign bus.busy    = busy_s;
endmodule

// File: doc/mux_arbiter_rr.md
Name: mux_arbiter_rr

Overview:
- Round-robin arbiter and sequencer that shares one W-bit output channel between N requesters.
- It drives the select of an N:1 data mux built from the team's 2:1 mux style. Each beat is handed downstream with a valid/ready handshake.
- A granted requester holds the channel for up to MAX_BURST beats, then priority rotates.
- Sits between several producer blocks and a single downstream consumer.

Parameters:
- N, 4, number of requesters (2..16).
- W, 8, data width per requester.
- MAX_BURST, 4, maximum accepted beats per grant before forced release (1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request per requester; held high while the requester has beats to send.
- d  input  N*W  flat requester data; requester i occupies d[i*W +: W].
- q_ready  input  1  downstream ready.
- gnt  output  N  one-hot grant, registered.
- sel  output  $clog2(N)  binary index of the granted requester, registered; drives the mux select.
- ack  output  N  one-cycle pulse to the granted requester when its beat is accepted.
- q_valid  output  1  downstream valid.
- q_data  output  W  muxed data.
- busy  output  1  high while in GRANT.

Behaviour:
- Interface: one clock `clk`. `rst_n` is asynchronous and active-low. All state updates on the rising edge of `clk`.
- Reset (rst_n=0, immediate, regardless of clock): state=IDLE, gnt=0, sel=0, rotation pointer ptr=0, beat count cnt=0. Outputs q_valid=0, q_data=0, ack=0, busy=0. Reset mid-burst abandons the burst with no further ack.
- State IDLE:
  - gnt=0, q_valid=0, q_data=0.
  - If any req bit is high, the winner is the first requesting index searching ptr, ptr+1, ... with wrap at N-1 to 0.
  - Next edge: state=GRANT, gnt=onehot(winner), sel=winner, cnt=0.
  - Latency is one cycle from req high to gnt/q_valid.
- State GRANT (combinational outputs):
  - q_valid = req[sel].
  - q_data = d[sel] while q_valid=1, else 0.
  - busy=1.
  - transfer = q_valid & q_ready; ack[sel]=transfer, all other ack bits 0.
- GRANT, counter: on a transfer edge, cnt increments. With q_ready=0, cnt holds and the grant holds indefinitely.
- GRANT, release condition: at an edge where (transfer and cnt==MAX_BURST-1) or req[sel]==0.
- GRANT, on release:
  - ptr = (sel+1) mod N.
  - Re-arbitrate in the same edge, searching from the new ptr; the released index is searched last.
  - If a winner exists, stay in GRANT with new gnt/sel and cnt=0. There is no bubble cycle.
  - Otherwise go to IDLE with gnt=0.
- Single active requester: after forced release it wins again on the very next cycle.
- Request withdrawn in GRANT (req[sel]=0): no transfer that cycle; release at the edge.
  - Requesters must keep req and their d slice stable until ack. Dropping req mid-beat is a protocol violation; the block releases anyway.
- Requests from non-granted indices are ignored until the next arbitration. There is no preemption.
- gnt is always zero or one-hot. sel equals the index of the gnt bit whenever gnt≠0.
- ack is never asserted when q_valid=0 or q_ready=0.

Test Plan:
- Reset, then req=0001, q_ready=1, MAX_BURST=4, d[0] takes 0x11..0x14 per ack → gnt=0001 one cycle after req; four acks with q_data 0x11,0x12,0x13,0x14; fifth cycle releases and re-grants index 0 with no bubble.
- req=1111 held, q_ready=1 → grants rotate 0,1,2,3,0 with 4 beats each; no cycle with q_valid=0 between bursts.
- req=0101, ptr=0, q_ready toggling 1,0,1,0 → cnt advances only on ready cycles; index 0 keeps the grant for 8 cycles (4 beats); then index 2 is granted.
- Index 1 granted, drops req after 2 beats with req=1001 elsewhere → release at that edge; next grant goes to index 3 (search from 2), not 0.
- rst_n asserted low asynchronously mid-burst (between clock edges) → gnt, sel, ack, q_valid, q_data, busy go to 0 immediately. After release, arbitration restarts from ptr=0.
- req=0000 in GRANT after the final beat → state IDLE; gnt=0; busy=0; q_data=0.
